// File: rtl/com_align_8_if.sv
// -----------------------------------------------------------------------------
// com_align_8_if
// Byte-stream bus between the 32-to-8 demux, the COM lane aligner and its
// consumer. All signals are synchronous to clk_4f, which is a plain port of the
// aligner.
//   data_in   [7:0] byte from the demux stage
//   valid_in        data_in qualifier
//   data_out  [7:0] forwarded byte (one cycle of latency)
//   valid_out       data_out qualifier
//   active          1 while the aligner is LOCKED
//   state_o   [1:0] aligner state: SEARCH=0, COUNT=1, LOCKED=2
// Modports: master = stream source / observer, slave = aligner.
// -----------------------------------------------------------------------------
interface com_align_8_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic [1:0] state_o;

   modport master (
      output data_in,
      output valid_in,
      input  data_out,
      input  valid_out,
      input  active,
      input  state_o
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output data_out,
      output valid_out,
      output active,
      output state_o
   );
endinterface

// File: rtl/com_align_8.sv
// -----------------------------------------------------------------------------
// com_align_8
// Lane aligner for the demuxed byte stream. It hunts for N_COM consecutive
// valid COM symbols (gaps with valid_in=0 are tolerated), then declares the lane
// active and forwards payload bytes with one registered cycle of latency. Lock
// is dropped after LOSS_CYC consecutive idle cycles.
// Ports:
//   clk_4f  byte clock, rising edge
//   reset   asynchronous, active-high reset
//   bus     com_align_8_if.slave (data_in/valid_in in; data_out/valid_out/
//           active/state_o out, all registered)
// Build option:
//   COM_ALIGN_STRIP_EN  when defined, valid COM bytes received in LOCKED are
//                       dropped instead of forwarded (they still count as
//                       traffic for the idle timer).
// -----------------------------------------------------------------------------
module com_align_8 #(
   parameter logic [7:0] COM_BYTE = 8'hBC,
   parameter logic [3:0] N_COM    = 4'd4,   // 1..15
   parameter logic [7:0] LOSS_CYC = 8'd8    // 1..255
) (
   input logic          clk_4f,
   input logic          reset,
   com_align_8_if.slave bus
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_COUNT  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_com_cnt;
   logic [3:0] w_com_cnt_nxt;
   logic [7:0] r_idle_cnt;
   logic [7:0] w_idle_cnt_nxt;
   logic [7:0] w_idle_inc;
   logic       w_valid_com;
   logic       w_fwd;
   logic [7:0] r_data_out;
   logic       r_valid_out;
   logic       r_active;

   function automatic logic is_com(input logic [7:0] b);
      return (b == COM_BYTE);
   endfunction

   // Next state, counters and forwarding decision
   always_comb begin
      w_state_nxt    = r_state;
      w_com_cnt_nxt  = r_com_cnt;
      w_idle_cnt_nxt = r_idle_cnt;
      w_fwd          = 1'b0;
      w_valid_com    = bus.valid_in & is_com(bus.data_in);
      // saturating increment so a long idle can never wrap back to a small count
      w_idle_inc     = (r_idle_cnt == 8'hFF) ? 8'hFF : (r_idle_cnt + 8'd1);

      case (r_state)
         ST_SEARCH: begin
            if (w_valid_com) begin
               if (N_COM == 4'd1) begin
                  w_state_nxt   = ST_LOCKED;
                  w_com_cnt_nxt = 4'd0;
               end else begin
                  w_state_nxt   = ST_COUNT;
                  w_com_cnt_nxt = 4'd1;
               end
            end else begin
               w_state_nxt   = ST_SEARCH;
               w_com_cnt_nxt = 4'd0;
            end
         end
         ST_COUNT: begin
            if (w_valid_com) begin
               if ((r_com_cnt + 4'd1) == N_COM) begin
                  // the locking COM itself is not forwarded: w_fwd stays 0
                  w_state_nxt   = ST_LOCKED;
                  w_com_cnt_nxt = 4'd0;
               end else begin
                  w_com_cnt_nxt = r_com_cnt + 4'd1;
               end
            end else if (bus.valid_in) begin
               w_state_nxt   = ST_SEARCH;
               w_com_cnt_nxt = 4'd0;
            end else begin
               // idle gap: the run is held, not broken
               w_com_cnt_nxt = r_com_cnt;
            end
         end
         ST_LOCKED: begin
            if (bus.valid_in) begin
               // any valid byte, even on the last idle cycle, keeps the lock
               w_idle_cnt_nxt = 8'd0;
`ifdef COM_ALIGN_STRIP_EN
               w_fwd          = ~w_valid_com;
`else
               w_fwd          = 1'b1;
`endif
            end else if (w_idle_inc >= LOSS_CYC) begin
               w_state_nxt    = ST_SEARCH;
               w_idle_cnt_nxt = 8'd0;
               w_com_cnt_nxt  = 4'd0;
            end else begin
               w_idle_cnt_nxt = w_idle_inc;
            end
         end
         default: begin
            w_state_nxt    = ST_SEARCH;
            w_com_cnt_nxt  = 4'd0;
            w_idle_cnt_nxt = 8'd0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         r_state    <= ST_SEARCH;
         r_com_cnt  <= 4'd0;
         r_idle_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_com_cnt  <= w_com_cnt_nxt;
         r_idle_cnt <= w_idle_cnt_nxt;
      end
   end

   // Registered outputs: forwarded byte and lock flag
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         r_data_out  <= 8'h00;
         r_valid_out <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_data_out  <= w_fwd ? bus.data_in : 8'h00;
         r_valid_out <= w_fwd;
         r_active    <= (w_state_nxt == ST_LOCKED);
      end
   end

   assign bus.data_out  = r_data_out;
   assign bus.valid_out = r_valid_out;
   assign bus.active    = r_active;
   assign bus.state_o   = r_state;

endmodule

// File: tb/tb_com_align_8.sv
// -----------------------------------------------------------------------------
// tb_com_align_8
// Directed-vector bench for com_align_8 with default parameters. Expected
// values are written by hand next to each stimulus step. Build with
// COM_ALIGN_STRIP_EN defined to cover the stripping variant.
// -----------------------------------------------------------------------------
module tb_com_align_8;

   logic clk_4f;
   logic reset;
   int   n_checks;
   int   n_pass;

   com_align_8_if bus ();

   com_align_8 dut (
      .clk_4f (clk_4f),
      .reset  (reset),
      .bus    (bus.slave)
   );

   // byte clock
   initial clk_4f = 1'b0;
   always #5 clk_4f = ~clk_4f;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // check all four outputs at once
   task automatic expect_out(input string tag, input logic [1:0] st, input logic act,
                             input logic vo, input logic [7:0] d);
      chk({tag, ".state"}, {30'd0, bus.state_o}, {30'd0, st});
      chk({tag, ".active"}, {31'd0, bus.active}, {31'd0, act});
      chk({tag, ".valid"}, {31'd0, bus.valid_out}, {31'd0, vo});
      chk({tag, ".data"}, {24'd0, bus.data_out}, {24'd0, d});
   endtask

   // apply one byte for one clock, return 1 time unit after the edge
   task automatic drive(input logic v, input logic [7:0] d);
      bus.valid_in = v;
      bus.data_in  = d;
      @(posedge clk_4f);
      #1;
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      reset        = 1'b1;
      bus.valid_in = 1'b0;
      bus.data_in  = 8'h00;
      repeat (2) @(posedge clk_4f);
      #1;
      expect_out("reset", 2'd0, 1'b0, 1'b0, 8'h00);
      reset = 1'b0;

      // lock on four COMs, then forward payload
      drive(1'b1, 8'hBC); expect_out("lk1", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("lk2", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("lk3", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("lk4", 2'd2, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 8'h11); expect_out("pl11", 2'd2, 1'b1, 1'b1, 8'h11);
      drive(1'b1, 8'h22); expect_out("pl22", 2'd2, 1'b1, 1'b1, 8'h22);

      // COM inside LOCKED: stripped or forwarded depending on build
      drive(1'b1, 8'h10); expect_out("st10", 2'd2, 1'b1, 1'b1, 8'h10);
      drive(1'b1, 8'hBC);
`ifdef COM_ALIGN_STRIP_EN
      expect_out("stBC", 2'd2, 1'b1, 1'b0, 8'h00);
`else
      expect_out("stBC", 2'd2, 1'b1, 1'b1, 8'hBC);
`endif
      drive(1'b1, 8'h20); expect_out("st20", 2'd2, 1'b1, 1'b1, 8'h20);

      // 7 idle cycles keep lock; A5 on the 8th clears the idle counter
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 8'h00);
      end
      expect_out("idle7", 2'd2, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 8'hA5); expect_out("a5", 2'd2, 1'b1, 1'b1, 8'hA5);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 8'h00);
      end
      expect_out("idle7b", 2'd2, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 8'h00); expect_out("loss", 2'd0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'h66); expect_out("nofwd66", 2'd0, 1'b0, 1'b0, 8'h00);

      // broken run: BC,BC,55,BC,BC,BC
      drive(1'b1, 8'hBC); expect_out("br1", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("br2", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'h55); expect_out("br55", 2'd0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("br3", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("br4", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("br5", 2'd1, 1'b0, 1'b0, 8'h00);

      // back to SEARCH, then gap tolerance: BC,BC, 3 idle, BC,BC
      drive(1'b1, 8'h77); expect_out("gp77", 2'd0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC);
      drive(1'b1, 8'hBC); expect_out("gp2", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00); expect_out("gpidle", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("gp3", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("gp4", 2'd2, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 8'h99); expect_out("gp99", 2'd2, 1'b1, 1'b1, 8'h99);

      // asynchronous reset mid-stream, between clock edges
      reset = 1'b1;
      #1;
      expect_out("arst", 2'd0, 1'b0, 1'b0, 8'h00);
      @(posedge clk_4f);
      #1;
      reset = 1'b0;
      drive(1'b1, 8'hBC);
      drive(1'b1, 8'hBC);
      drive(1'b1, 8'hBC); expect_out("rl3", 2'd1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 8'hBC); expect_out("rl4", 2'd2, 1'b1, 1'b0, 8'h00);
      drive(1'b1, 8'h42); expect_out("rl42", 2'd2, 1'b1, 1'b1, 8'h42);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
